time_tune_ctrl: RTL and testbench

Tuning controller for the clock and alarm time registers. It snapshots the target time when tune mode is entered and holds a shadow copy. Up/down keys step the field chosen by tune_status, with wrap-around and hold-to-repeat. On exit from tune mode it issues a one-cycle load strobe to the clock counter or the alarm register. It sits between tune_status_mgr and the timekeeping/alarm datapath, and drives the display during tuning.

---
 rtl/time_tune_ctrl.sv | 100 ++++++++++
 tb/tb_time_tune_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/time_tune_ctrl.sv
// time_tune_ctrl: shadow-register tuning of clock/alarm time with key stepping, auto-repeat and load strobes
module time_tune_ctrl #(
  parameter logic [23:0] HOLD_CYCLES   = 24'd500_000,
  parameter logic [23:0] REPEAT_CYCLES = 24'd100_000,
  parameter logic [3:0]  KEY_UP        = 4'b1000,
  parameter logic [3:0]  KEY_DOWN      = 4'b0001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] neg_keys_filtered,
  input  logic [3:0] keys_level,
  input  logic [2:0] sys_status,
  input  logic [1:0] tune_status,
  input  logic [4:0] time_hour,
  input  logic [5:0] time_min,
  input  logic [5:0] time_sec,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  input  logic [5:0] alarm_sec,
  output logic [4:0] edit_hour,
  output logic [5:0] edit_min,
  output logic [5:0] edit_sec,
  output logic       edit_active,
  output logic       time_load,
  output logic       alarm_load
);
  typedef enum logic [1:0] {IDLE, EDIT_CLK, EDIT_ALM} state_t;
  state_t state, state_next;
  logic [23:0] cnt, cnt_next;
  logic [4:0] hour_next;
  logic [5:0] min_next, sec_next;
  logic grp_clk, grp_alm, held, pulse, tick, up, down, step_en;
  assign grp_clk = sys_status == 3'd2 || sys_status == 3'd3;
  assign grp_alm = sys_status == 3'd4 || sys_status == 3'd5;
  assign held    = keys_level == KEY_UP || keys_level == KEY_DOWN;
  assign pulse   = |neg_keys_filtered;
  // a press pulse suppresses the tick, so press and tick never double-step
  assign tick     = held && !pulse && cnt == HOLD_CYCLES - 24'd1;
  assign cnt_next = (pulse || !held) ? '0 : tick ? HOLD_CYCLES - REPEAT_CYCLES : cnt + 24'd1;
  assign up       = neg_keys_filtered == KEY_UP   || (tick && keys_level == KEY_UP);
  assign down     = neg_keys_filtered == KEY_DOWN || (tick && keys_level == KEY_DOWN);
  assign step_en  = tune_status != 2'd0 &&
                    ((state == EDIT_CLK && sys_status == 3'd3) || (state == EDIT_ALM && sys_status == 3'd5));
  assign edit_active = state != IDLE;
  always_comb begin
    state_next = state;
    hour_next  = edit_hour;
    min_next   = edit_min;
    sec_next   = edit_sec;
    time_load  = 1'b0;
    alarm_load = 1'b0;
    case (state)
      IDLE: begin
        if (grp_clk) begin
          state_next = EDIT_CLK;
          hour_next  = time_hour > 5'd23 ? 5'd0 : time_hour;
          min_next   = time_min > 6'd59 ? 6'd0 : time_min;
          sec_next   = time_sec > 6'd59 ? 6'd0 : time_sec;
        end else if (grp_alm) begin
          state_next = EDIT_ALM;
          hour_next  = alarm_hour > 5'd23 ? 5'd0 : alarm_hour;
          min_next   = alarm_min > 6'd59 ? 6'd0 : alarm_min;
          sec_next   = alarm_sec > 6'd59 ? 6'd0 : alarm_sec;
        end
      end
      EDIT_CLK: if (!grp_clk) begin
        time_load  = 1'b1;
        state_next = IDLE;
      end
      EDIT_ALM: if (!grp_alm) begin
        alarm_load = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (step_en && (up || down)) begin
      if (tune_status == 2'd1)
        sec_next = up ? (edit_sec == 6'd59 ? 6'd0 : edit_sec + 6'd1) : (edit_sec == 6'd0 ? 6'd59 : edit_sec - 6'd1);
      if (tune_status == 2'd2)
        min_next = up ? (edit_min == 6'd59 ? 6'd0 : edit_min + 6'd1) : (edit_min == 6'd0 ? 6'd59 : edit_min - 6'd1);
      if (tune_status == 2'd3)
        hour_next = up ? (edit_hour == 5'd23 ? 5'd0 : edit_hour + 5'd1) : (edit_hour == 5'd0 ? 5'd23 : edit_hour - 5'd1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      edit_hour <= '0;
      edit_min  <= '0;
      edit_sec  <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      edit_hour <= hour_next;
      edit_min  <= min_next;
      edit_sec  <= sec_next;
    end
  end
endmodule

// File: tb/tb_time_tune_ctrl.sv
// tb_time_tune_ctrl: directed-vector self-checking bench for time_tune_ctrl
module tb_time_tune_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] neg_keys_filtered, keys_level;
  logic [2:0] sys_status;
  logic [1:0] tune_status;
  logic [4:0] time_hour, alarm_hour, edit_hour;
  logic [5:0] time_min, time_sec, alarm_min, alarm_sec, edit_min, edit_sec;
  logic edit_active, time_load, alarm_load;
  int total = 0;
  int passed = 0;
  localparam logic [3:0] UP = 4'b1000;
  localparam logic [3:0] DN = 4'b0001;

  time_tune_ctrl #(.HOLD_CYCLES(24'd10), .REPEAT_CYCLES(24'd4)) dut (
    .clk(clk), .rst_n(rst_n), .neg_keys_filtered(neg_keys_filtered), .keys_level(keys_level),
    .sys_status(sys_status), .tune_status(tune_status),
    .time_hour(time_hour), .time_min(time_min), .time_sec(time_sec),
    .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_sec(alarm_sec),
    .edit_hour(edit_hour), .edit_min(edit_min), .edit_sec(edit_sec),
    .edit_active(edit_active), .time_load(time_load), .alarm_load(alarm_load)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] k, input int n = 1);
    repeat (n) begin
      neg_keys_filtered = k;
      cyc();
      neg_keys_filtered = 4'd0;
    end
  endtask

  task automatic chk_edit(input string tag, input int h, input int m, input int s);
    chk({tag, ".h"}, 32'(edit_hour), 32'(h));
    chk({tag, ".m"}, 32'(edit_min), 32'(m));
    chk({tag, ".s"}, 32'(edit_sec), 32'(s));
  endtask

  initial begin
    rst_n = 1'b0;
    neg_keys_filtered = 4'd0;
    keys_level = 4'd0;
    sys_status = 3'd0;
    tune_status = 2'd0;
    {time_hour, time_min, time_sec} = {5'd12, 6'd34, 6'd56};
    {alarm_hour, alarm_min, alarm_sec} = {5'd7, 6'd0, 6'd0};
    cyc(2);
    chk_edit("rst_edit", 0, 0, 0);
    chk("rst_active", 32'(edit_active), 0);
    chk("rst_tload", 32'(time_load), 0);
    chk("rst_aload", 32'(alarm_load), 0);
    rst_n = 1'b1;
    cyc();
    sys_status = 3'd2;
    #1 chk("enter_tload", 32'(time_load), 0);
    cyc();
    chk_edit("snap_clk", 12, 34, 56);
    chk("snap_active", 32'(edit_active), 1);
    chk("snap_tload", 32'(time_load), 0);
    sys_status = 3'd3;
    tune_status = 2'd1;
    press(UP, 3);
    chk_edit("sec_to59", 12, 34, 59);
    press(UP);
    chk_edit("sec_wrap_up", 12, 34, 0);
    press(DN);
    chk_edit("sec_wrap_dn", 12, 34, 59);
    tune_status = 2'd3;
    press(DN, 12);
    chk_edit("hour_to0", 0, 34, 59);
    press(DN);
    chk_edit("hour_wrap_dn", 23, 34, 59);
    press(UP);
    chk_edit("hour_wrap_up", 0, 34, 59);
    press(4'b1001);
    chk_edit("both_keys", 0, 34, 59);
    tune_status = 2'd2;
    keys_level = UP;
    press(UP);
    chk("hold_press", 32'(edit_min), 35);
    cyc(9);
    chk("hold_pre_tick", 32'(edit_min), 35);
    cyc();
    chk("hold_tick1", 32'(edit_min), 36);
    cyc(3);
    chk("hold_pre_tick2", 32'(edit_min), 36);
    cyc();
    chk("hold_tick2", 32'(edit_min), 37);
    keys_level = 4'd0;
    cyc();
    keys_level = UP;
    cyc(9);
    chk("rel_cleared", 32'(edit_min), 37);
    cyc();
    chk("rel_tick", 32'(edit_min), 38);
    keys_level = 4'd0;
    sys_status = 3'd2;
    press(UP);
    chk("no_step_sel", 32'(edit_min), 38);
    sys_status = 3'd0;
    #1 chk("exit_tload", 32'(time_load), 1);
    chk("exit_active", 32'(edit_active), 1);
    chk("exit_aload", 32'(alarm_load), 0);
    cyc();
    chk("exit_tload_end", 32'(time_load), 0);
    chk("exit_active_end", 32'(edit_active), 0);
    chk_edit("exit_hold", 0, 38, 59);
    sys_status = 3'd4;
    cyc();
    chk_edit("snap_alm", 7, 0, 0);
    sys_status = 3'd5;
    tune_status = 2'd2;
    press(UP, 30);
    chk_edit("alm_edit", 7, 30, 0);
    sys_status = 3'd0;
    #1 chk("alm_aload", 32'(alarm_load), 1);
    chk("alm_tload", 32'(time_load), 0);
    chk_edit("alm_load_data", 7, 30, 0);
    cyc();
    chk("alm_aload_end", 32'(alarm_load), 0);
    sys_status = 3'd2;
    cyc();
    chk_edit("resnap_clk", 12, 34, 56);
    sys_status = 3'd3;
    cyc();
    sys_status = 3'd4;
    #1 chk("direct_tload", 32'(time_load), 1);
    chk("direct_aload", 32'(alarm_load), 0);
    cyc();
    chk("direct_tload_end", 32'(time_load), 0);
    chk_edit("direct_stable", 12, 34, 56);
    cyc();
    chk_edit("direct_snap", 7, 0, 0);
    chk("direct_active", 32'(edit_active), 1);
    sys_status = 3'd0;
    cyc();
    {alarm_hour, alarm_min, alarm_sec} = {5'd25, 6'd61, 6'd30};
    sys_status = 3'd4;
    cyc();
    chk_edit("clamp", 0, 0, 30);
    sys_status = 3'd0;
    cyc();
    sys_status = 3'd2;
    cyc(2);
    #3 rst_n = 1'b0;
    #1 chk_edit("arst_edit", 0, 0, 0);
    chk("arst_active", 32'(edit_active), 0);
    chk("arst_tload", 32'(time_load), 0);
    sys_status = 3'd0;
    cyc();
    rst_n = 1'b1;
    #1 chk("post_rst_tload", 32'(time_load), 0);
    cyc();
    chk("post_rst_tload2", 32'(time_load), 0);
    chk("post_rst_active", 32'(edit_active), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
